// File: rtl/peripheral_bus_pkg.sv
// Shared types and helpers for the peripheral bus bridge and its address decoder.
package peripheral_bus_pkg;

  // Bridge transaction phases.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_DRAIN   = 2'd3
  } bridge_state_e;

  // Widest slave count and address/data width the helpers are sized for.
  localparam int MAX_SLAVES = 16;
  localparam int MAX_WIDTH  = 64;
  localparam int MAX_PACKED = MAX_SLAVES * MAX_WIDTH;

  // Read data returned with every error response (sliced to DATA_WIDTH by users).
  localparam logic [MAX_WIDTH-1:0] ERROR_READ_DATA = '1;

  // Extract field idx of a packed per-slave parameter whose fields are width bits wide.
  function automatic logic [MAX_WIDTH-1:0] slave_field(input logic [MAX_PACKED-1:0] packed_v,
                                                       input int idx,
                                                       input int width);
    logic [MAX_PACKED-1:0] shifted;
    logic [MAX_WIDTH-1:0]  keep;
    shifted = packed_v >> (idx * width);
    keep    = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    return shifted[MAX_WIDTH-1:0] & keep;
  endfunction

endpackage

// File: rtl/peripheral_addr_decoder.sv
// Combinational address-window decoder: reports whether any slave window matches
// and the index of the lowest-numbered matching slave.
module peripheral_addr_decoder
  import peripheral_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam logic [MAX_PACKED-1:0] BASE_EXT = MAX_PACKED'(SLAVE_BASE);
  localparam logic [MAX_PACKED-1:0] MASK_EXT = MAX_PACKED'(SLAVE_MASK);

  logic [NUM_SLAVES-1:0] hit_vec;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_window
    localparam logic [ADDR_WIDTH-1:0] BASE_I = ADDR_WIDTH'(slave_field(BASE_EXT, gi, ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] MASK_I = ADDR_WIDTH'(slave_field(MASK_EXT, gi, ADDR_WIDTH));
    assign hit_vec[gi] = ((addr_i & MASK_I) == (BASE_I & MASK_I));
  end

  // Priority select: scan from the top so the lowest matching index is the last writer.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Peripheral bus bridge: decodes the master's address onto one of NUM_SLAVES slave
// channels, runs one transaction at a time with a per-access timeout, and returns an
// error response for unmapped, conflicting or hung accesses.
module peripheral_bus_bridge
  import peripheral_bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FF00}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           read_request,
  input  logic                           write_request,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           response,
  output logic                           error,
  output logic [NUM_SLAVES-1:0]          slave_read,
  output logic [NUM_SLAVES-1:0]          slave_write,
  output logic [ADDR_WIDTH-1:0]          slave_addr,
  output logic [DATA_WIDTH-1:0]          slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]          slave_response
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA    = ERROR_READ_DATA[DATA_WIDTH-1:0];

  bridge_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  op_write_q, op_write_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  resp_q, resp_d;
  logic                  err_q, err_d;
  logic [NUM_SLAVES-1:0] srd_q, srd_d;
  logic [NUM_SLAVES-1:0] swr_q, swr_d;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_resp;
  logic [CNT_W-1:0]      cnt_inc;

  peripheral_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr_i (addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign dec_onehot = NUM_SLAVES'(1) << dec_idx;

  // Route the selected slave's read data and completion; other slaves are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_rdata = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_resp  = slave_response[i];
      end
    end
  end

  // Next-state and registered-output logic; strobes and response default low.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    op_write_d = op_write_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    resp_d     = 1'b0;
    err_d      = 1'b0;
    srd_d      = '0;
    swr_d      = '0;
    cnt_inc    = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (read_request || write_request) begin
          addr_d     = addr;
          wdata_d    = write_data;
          op_write_d = write_request;
          sel_d      = dec_idx;
          cnt_d      = '0;
          if ((read_request && write_request) || !dec_hit) begin
            // Conflicting request or no window: answer immediately, no slave touched.
            state_d = ST_RESPOND;
            resp_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end else begin
            state_d = ST_ACCESS;
            srd_d   = read_request  ? dec_onehot : '0;
            swr_d   = write_request ? dec_onehot : '0;
          end
        end
      end

      ST_ACCESS: begin
        if (sel_resp) begin
          // A response in the timeout cycle still counts as success.
          state_d = ST_RESPOND;
          resp_d  = 1'b1;
          rdata_d = op_write_q ? '0 : sel_rdata;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d = ST_RESPOND;
          resp_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
          srd_d = srd_q;
          swr_d = swr_q;
        end
      end

      ST_RESPOND: state_d = ST_DRAIN;

      // Hold here until the master lets go, so a held request is not re-issued.
      ST_DRAIN: begin
        if (!read_request && !write_request) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops strobes immediately, even mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      op_write_q <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      srd_q      <= '0;
      swr_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      op_write_q <= op_write_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      srd_q      <= srd_d;
      swr_q      <= swr_d;
    end
  end

  assign read_data        = rdata_q;
  assign response         = resp_q;
  assign error            = err_q;
  assign slave_read       = srd_q;
  assign slave_write      = swr_q;
  assign slave_addr       = addr_q;
  assign slave_write_data = wdata_q;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Bench for peripheral_bus_bridge: a transaction-level model predicts response
// latency, strobe window and returned data; a monitor compares every cycle.
module tb_peripheral_bus_bridge;

  localparam int NS  = 4;
  localparam int TMO = 8;

  logic           clk;
  logic           rst;
  logic           read_request;
  logic           write_request;
  logic [31:0]    addr;
  logic [31:0]    write_data;
  logic [31:0]    read_data;
  logic           response;
  logic           error;
  logic [NS-1:0]  slave_read;
  logic [NS-1:0]  slave_write;
  logic [31:0]    slave_addr;
  logic [31:0]    slave_write_data;
  logic [NS*32-1:0] slave_read_data;
  logic [NS-1:0]  slave_response;

  peripheral_bus_bridge #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .SLAVE_BASE     ({32'h0000_1000, 32'h0000_2000, 32'h0000_1100, 32'h0000_1000}),
    .SLAVE_MASK     ({32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00}),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .read_request     (read_request),
    .write_request    (write_request),
    .addr             (addr),
    .write_data       (write_data),
    .read_data        (read_data),
    .response         (response),
    .error            (error),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_addr       (slave_addr),
    .slave_write_data (slave_write_data),
    .slave_read_data  (slave_read_data),
    .slave_response   (slave_response)
  );

  // Address map as the bench understands it (slave 3 overlaps slaves 0 and 1).
  logic [31:0] win_base [NS] = '{32'h0000_1000, 32'h0000_1100, 32'h0000_2000, 32'h0000_1000};
  logic [31:0] win_mask [NS] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Current expected transaction.
  bit          m_active = 0;
  bit          m_rd, m_wr, m_err;
  int          m_idx, m_lat, m_t0;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & win_mask[i]) == (win_base[i] & win_mask[i])) return i;
    return -1;
  endfunction

  // Per-cycle compare against the transaction model.
  always @(posedge clk) begin
    int         k;
    bit         exp_resp;
    logic [3:0] exp_strb;
    #2;
    k        = cyc - m_t0;
    exp_resp = m_active && (k == m_lat - 1);
    exp_strb = (m_active && m_idx >= 0 && k >= 0 && k < m_lat - 1) ? (4'(1) << m_idx) : 4'h0;
    chk("mon_response", 64'(response), 64'(exp_resp));
    chk("mon_slave_read", 64'(slave_read), 64'(m_rd ? exp_strb : 4'h0));
    chk("mon_slave_write", 64'(slave_write), 64'(m_wr ? exp_strb : 4'h0));
    if (exp_resp) begin
      chk("mon_error", 64'(error), 64'(m_err));
      chk("mon_read_data", 64'(read_data), 64'(m_rdata));
    end
    if (exp_strb != 4'h0) begin
      chk("mon_slave_addr", 64'(slave_addr), 64'(m_addr));
      chk("mon_slave_wdata", 64'(slave_write_data), 64'(m_wdata));
    end
  end

  // One master transaction plus slave behaviour; lit_* are hand-computed expectations.
  task automatic txn(input string name, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int waits, input logic [31:0] sdata,
                     input int hold, input bit late_poke,
                     input int lit_lat, input int lit_strb,
                     input logic [31:0] lit_rdata, input bit lit_err);
    int idx, k, seen_lat, strb;
    bit done, tmo;
    @(negedge clk);
    idx = (rd && wr) ? -1 : model_decode(a);
    tmo = (idx >= 0) && (waits < 0 || waits >= TMO);
    m_rd    = rd;
    m_wr    = wr;
    m_idx   = idx;
    m_addr  = a;
    m_wdata = wd;
    m_lat   = (idx < 0) ? 1 : (tmo ? TMO + 1 : waits + 2);
    m_err   = (idx < 0) || tmo;
    m_rdata = m_err ? 32'hFFFF_FFFF : (wr ? 32'h0 : sdata);
    for (int i = 0; i < NS; i++)
      slave_read_data[i*32 +: 32] = (i == idx) ? sdata : (32'hDEAD_0000 | 32'(i));
    slave_response = '0;
    addr          = a;
    write_data    = wd;
    read_request  = rd;
    write_request = wr;
    m_t0     = cyc + 1;
    m_active = 1;
    done = 0;
    strb = 0;
    seen_lat = -1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      k = cyc - m_t0;
      if ((|slave_read) || (|slave_write)) strb++;
      if (response) begin
        done = 1;
        seen_lat = k + 1;
        chk({name, "_rdata"}, 64'(read_data), 64'(lit_rdata));
        chk({name, "_error"}, 64'(error), 64'(lit_err));
      end
      slave_response = '0;
      if (!done && idx >= 0) begin
        if (waits >= 0 && k == waits) slave_response[idx] = 1'b1;
        if (k == 1) slave_response[(idx + 1) % NS] = 1'b1;  // stray, must be ignored
      end
    end
    if (!done) $display("FAIL %s_wait: no response within 40 cycles", name);
    if (!done) begin tests++; fails++; end
    chk({name, "_latency"}, 64'(seen_lat), 64'(lit_lat));
    chk({name, "_strobe_cycles"}, 64'(strb), 64'(lit_strb));
    repeat (hold) @(negedge clk);
    read_request  = 1'b0;
    write_request = 1'b0;
    repeat (3) begin
      @(negedge clk);
      slave_response = '0;
      if (late_poke && idx >= 0) slave_response[idx] = 1'b1;
    end
    @(negedge clk);
    slave_response = '0;
    $display("[TB] txn %s rd=%0d wr=%0d addr=%h latency=%0d strobes=%0d", name, rd, wr, a, seen_lat, strb);
  endtask

  initial begin
    rst = 1'b0;
    read_request = 1'b0;
    write_request = 1'b0;
    addr = '0;
    write_data = '0;
    slave_read_data = '0;
    slave_response = '0;
    m_rd = 0; m_wr = 0; m_err = 0; m_idx = -1; m_lat = 1; m_t0 = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_read_data", 64'(read_data), 64'h0);
    chk("reset_slave_addr", 64'(slave_addr), 64'h0);
    chk("reset_slave_wdata", 64'(slave_write_data), 64'h0);
    chk("reset_response", 64'(response), 64'h0);
    chk("reset_strobes", 64'({slave_read, slave_write}), 64'h0);
    $display("[TB] reset checked");

    txn("rd_s1",       1, 0, 32'h0000_1100, 32'h0,          0, 32'hA5A5_0001, 0, 0, 2, 1, 32'hA5A5_0001, 0);
    txn("wr_s0",       0, 1, 32'h0000_1000, 32'h0000_00FF,  3, 32'h1234_5678, 0, 0, 5, 4, 32'h0,         0);
    txn("rd_unmapped", 1, 0, 32'h0000_9000, 32'h0,          0, 32'h0,         0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    txn("rd_timeout",  1, 0, 32'h0000_2000, 32'h0,         -1, 32'h0000_0055, 0, 1, 9, 8, 32'hFFFF_FFFF, 1);
    txn("rd_wr_both",  1, 1, 32'h0000_1100, 32'h0000_0077,  0, 32'h0000_0099, 3, 0, 1, 0, 32'hFFFF_FFFF, 1);

    // Reset in the middle of an access: strobes must fall without waiting for a clock.
    @(negedge clk);
    m_rd = 1; m_wr = 0; m_idx = 2; m_addr = 32'h0000_2010; m_wdata = 32'h0;
    m_lat = TMO + 1; m_err = 1; m_rdata = 32'hFFFF_FFFF;
    addr = 32'h0000_2010;
    write_data = 32'h0;
    read_request = 1'b1;
    m_t0 = cyc + 1;
    m_active = 1;
    repeat (2) @(negedge clk);
    chk("rst_pre_strobe", 64'(slave_read), 64'h4);
    m_active = 0;
    rst = 1'b1;
    #1;
    chk("rst_strobe_drop", 64'(slave_read), 64'h0);
    chk("rst_no_response", 64'(response), 64'h0);
    @(negedge clk);
    read_request = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] txn reset_mid_access strobe dropped");

    txn("wr_s3",         0, 1, 32'h0000_1234, 32'h0000_CAFE, 1, 32'h0000_0001, 0, 0, 3, 2, 32'h0,         0);
    txn("rd_s2_wait",    1, 0, 32'h0000_20AC, 32'h0,         2, 32'h0BAD_F00D, 0, 0, 4, 3, 32'h0BAD_F00D, 0);
    txn("rd_overlap_s0", 1, 0, 32'h0000_10F0, 32'h0,         0, 32'h1357_2468, 0, 0, 2, 1, 32'h1357_2468, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/peripheral_bus_bridge.md
# peripheral_bus_bridge

Parametrised peripheral interconnect between the core's peripheral port and up to `NUM_SLAVES` memory-mapped devices (LEDs, UART, GPIO, timers). It replaces the single point-to-point peripheral connection with address-window decoding, one outstanding transaction at a time, a per-access timeout and an error response for unmapped or hung accesses. Master side uses the core's level request / single-cycle response handshake; slave side presents the same handshake per slave.

## Interface
- `NUM_SLAVES`, 4, number of slave channels (1..16)
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `SLAVE_BASE`, {NUM_SLAVES{32'h0}}, packed base addresses, slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `SLAVE_MASK`, {NUM_SLAVES{32'hFFFF_FF00}}, packed masks; slave i hit when (addr & mask_i) == (base_i & mask_i)
- `TIMEOUT_CYCLES`, 255, max cycles in ACCESS before error (>=1)
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; asynchronous, active-high
- `read_request`  in  1  master read, held until `response`
- `write_request`  in  1  master write, held until `response`
- `addr`  in  ADDR_WIDTH  master address
- `write_data`  in  DATA_WIDTH  master write data
- `read_data`  out  DATA_WIDTH  registered read data, valid with `response`
- `response`  out  1  one-cycle completion pulse
- `error`  out  1  valid with `response`: unmapped, timeout or protocol error
- `slave_read`  out  NUM_SLAVES  one-hot read strobe, held until slave responds
- `slave_write`  out  NUM_SLAVES  one-hot write strobe
- `slave_addr`  out  ADDR_WIDTH  latched address, shared
- `slave_write_data`  out  DATA_WIDTH  latched write data, shared
- `slave_read_data`  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- `slave_response`  in  NUM_SLAVES  per-slave completion

## Operation
- States: IDLE, ACCESS, RESPOND, DRAIN.
- IDLE: on `read_request` or `write_request`, latch addr, write_data, op, and decoded index. Exactly one request + hit -> ACCESS. No hit -> RESPOND, error=1. Both requests high -> RESPOND, error=1, no slave touched.
- Overlapping windows: lowest index wins.
- ACCESS: assert `slave_read`/`slave_write` bit of selected slave only; timeout counter increments each cycle. `slave_response[sel]` -> capture `slave_read_data[sel]` (reads only; writes capture 0), RESPOND, error=0. Counter reaching TIMEOUT_CYCLES without response -> RESPOND, error=1. Response and timeout in same cycle: response wins. Responses from non-selected slaves ignored.
- RESPOND: `response`=1 one cycle with `read_data`/`error`; strobes low. -> DRAIN.
- DRAIN: wait until both master requests low, then IDLE (blocks re-issue of a held request).
- Error read data: `ERROR_READ_DATA` = all ones.
- Counter width $clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS.

## Timing
- Reset (async, any state): state=IDLE; `response`, `error`, `slave_read`, `slave_write` = 0; `read_data`, `slave_addr`, `slave_write_data`, counter = 0. Strobes drop immediately, mid-transaction included; aborted transaction yields no response.
- All outputs registered.
- Request sampled at edge E0: unmapped -> `response` high cycle after E0 (latency 1). Mapped -> strobe high cycle after E0; slave responding in first strobe cycle -> `response` next cycle (latency 2); each slave wait cycle adds 1.
- Timeout: strobe high exactly TIMEOUT_CYCLES cycles, then `response`+`error`.
- Minimum back-to-back: request drop seen in DRAIN -> IDLE next cycle -> new request accepted; 4 cycles per zero-wait access.

## Structure
- Package `peripheral_bus_pkg`: state enum, `ERROR_READ_DATA`, helper to extract packed base/mask.
- Sub-module `peripheral_addr_decoder`: combinational, addr + packed base/mask -> hit flag + binary index (priority to lowest index).
- Bridge holds FSM, latches, counter, read-data mux.

## Test plan
- Read slave 1 (base 0x1100, mask 0xFFFF_FF00), slave responds first cycle with 0xA5A5_0001 -> `response` 2 cycles after request, read_data=0xA5A5_0001, error=0, only slave_read[1] pulsed.
- Write 0x0000_00FF to 0x0000_1000 (slave 0) with 3 wait cycles -> slave_write[0] high 4 cycles, slave_write_data=0xFF, response latency 5, error=0.
- Read 0x0000_9000 (unmapped) -> response 1 cycle later, error=1, read_data=0xFFFF_FFFF, no strobes.
- TIMEOUT_CYCLES=8, slave never responds -> strobe high 8 cycles, then response, error=1; late slave_response afterwards ignored.
- Read and write asserted together -> error response, no strobes; master holds request 3 cycles after response -> single response only (DRAIN).
- Assert `rst` during ACCESS -> strobes 0 same cycle, no response; next request after release completes normally.
